// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port RAM read sequencer.
// Holds the FSM state encoding and the read-buffer sizing.
package dpram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned RD_BUF_DEPTH = 2;
  localparam int unsigned RD_CNT_W     = $clog2(RD_BUF_DEPTH + 1);

endpackage

// File: rtl/fifo2.sv
// Two-entry synchronous FIFO used to absorb RAM read latency and backpressure.
// Ports:
//   clk, rst    clock and synchronous active-high reset (clears storage too)
//   push_i      write wdata_i (accepted when not full, or full with pop_i)
//   wdata_i     write data
//   pop_i       remove head entry (ignored when empty)
//   rdata_o     head entry data
//   count_o     number of stored entries (0..2)
module fifo2
  import dpram_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [DW-1:0]       wdata_i,
  input  logic                pop_i,
  output logic [DW-1:0]       rdata_o,
  output logic [RD_CNT_W-1:0] count_o
);

  logic [DW-1:0]       mem_q [RD_BUF_DEPTH];
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [RD_CNT_W-1:0] count_q, count_d;
  logic                do_pop;
  logic                do_push;

  // Push into a full FIFO only succeeds when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != RD_CNT_W'(RD_BUF_DEPTH)) || do_pop);
    rd_d    = do_pop  ? ~rd_q : rd_q;
    wr_d    = do_push ? ~wr_q : wr_q;
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + RD_CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - RD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RD_BUF_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
      end
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/dpram_reader.sv
// Read-side sequencer for the single-clock dual-port RAM: on start, streams
// len words from RAM port B beginning at base onto a valid/ready stream.
// Ports:
//   clk, rst    clock (shared with RAM port B), synchronous active-high reset
//   start       command strobe, accepted only when idle
//   base, len   first address and word count, sampled with an accepted start
//   busy, done  not-idle flag and one-cycle completion pulse
//   ram_addr    registered RAM read address
//   ram_dout    RAM read data, valid one cycle after the address
//   m_data, m_valid, m_ready, m_last   output stream
module dpram_reader
  import dpram_pkg::*;
#(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_dout,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last
);

  localparam int unsigned LW    = AW + 1;
  localparam int unsigned OCC_W = RD_CNT_W + 1;

  state_e              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [LW-1:0]       issue_left_q, issue_left_d;
  logic [LW-1:0]       out_left_q, out_left_d;
  logic                in_flight_q, in_flight_d;

  logic [RD_CNT_W-1:0] buf_count;
  logic [DW-1:0]       buf_rdata;
  logic [OCC_W-1:0]    occ;
  logic                accept;
  logic                issue;
  logic                pop;

  fifo2 #(
    .DW (DW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_flight_q),
    .wdata_i (ram_dout),
    .pop_i   (pop),
    .rdata_o (buf_rdata),
    .count_o (buf_count)
  );

  // Stream side: head of the buffer; last flag tracks remaining output words.
  assign m_valid = (buf_count != '0);
  assign m_data  = buf_rdata;
  assign m_last  = m_valid && (out_left_q == LW'(1));
  assign pop     = m_valid && m_ready;
  assign accept  = (state_q == ST_IDLE) && start;

  // Words buffered plus the one in flight, less the one leaving now, must
  // stay below the buffer depth for another read to be safe.
  always_comb begin
    occ   = OCC_W'(buf_count) + OCC_W'(in_flight_q) - OCC_W'(pop);
    issue = (state_q == ST_RUN) && (issue_left_q != '0) &&
            (occ < OCC_W'(RD_BUF_DEPTH));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (pop && m_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // Address, count and in-flight next values.
  always_comb begin
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    in_flight_d  = issue;
    if (accept) begin
      addr_d       = base;
      issue_left_d = len;
      out_left_d   = len;
    end
    if (issue) begin
      addr_d       = addr_q + AW'(1);
      issue_left_d = issue_left_q - LW'(1);
    end
    if (pop) begin
      out_left_d = out_left_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      in_flight_q  <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      in_flight_q  <= in_flight_d;
    end
  end

  assign ram_addr = addr_q;

endmodule
